// File: rtl/sar_pkg.sv
// Shared types and helpers for the N-bit SAR controller.
// The state enum and the index-width helper used to size counters.
package sar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RSTC   = 3'd3,
    ST_LATCH  = 3'd4
  } sar_state_t;

  // Width needed to index n items (clog2), never narrower than one bit.
  function automatic int idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/sar_tmo_cnt.sv
// WAIT-phase timeout counter for the SAR controller.
// Cleared while 'load' is high and counts cycles while 'run' is high.
// 'expire' flags the TIMEOUT_CYC-th consecutive run cycle, so the owner
// can force a decision on that cycle.
module sar_tmo_cnt
  import sar_pkg::*;
#(
  parameter int TIMEOUT_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int CW = idx_w(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  assign expire = run && (cnt == CW'(TIMEOUT_CYC - 1));

  // Cycle counter: cleared on load, advances while running, saturates at expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {CW{1'b0}};
    end else if (load) begin
      cnt <= {CW{1'b0}};
    end else if (run && !expire) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/sar_ctrl_nb.sv
// N-bit successive-approximation controller with sample/convert FSM.
// Sequence per conversion: SAMPLE (CKS high for SAMPLE_CYC cycles), then for
// each bit MSB..LSB a WAIT phase (CKC high until RDY) and a one-cycle RSTC,
// then LATCH which publishes DATA with a one-cycle CKO strobe.
// All outputs are registers loaded from the next state, so they line up
// with the state they describe.
// Optional build macro SAR_TIMEOUT_EN: adds a WAIT timeout (TIMEOUT_CYC)
// and the sticky ERR output.
module sar_ctrl_nb
  import sar_pkg::*;
#(
  parameter int N_BITS      = 9,
  parameter int SAMPLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              RDY,
  input  logic              CMP_P,
  input  logic              CMP_N,
  output logic              CKS,
  output logic              CKSB,
  output logic              CKC,
  output logic [N_BITS-1:0] CF,
  output logic [N_BITS-1:0] SWP,
  output logic [N_BITS-1:0] SWN,
  output logic [N_BITS-1:0] DATA,
  output logic              CKO
`ifdef SAR_TIMEOUT_EN
  ,
  output logic              ERR
`endif
);

  localparam int KW = idx_w(N_BITS);
  localparam int SW = idx_w(SAMPLE_CYC + 1);

  sar_state_t        state;
  sar_state_t        state_next;
  logic [KW-1:0]     k;
  logic [SW-1:0]     samp_cnt;
  logic              samp_done;
  logic              samp_entry;
  logic              decide;
  logic              bit_val;
  logic              tmo_expire;
  logic [N_BITS-1:0] k_mask;

  assign samp_done  = (samp_cnt == SW'(SAMPLE_CYC - 1));
  assign samp_entry = (state_next == ST_SAMPLE) && (state != ST_SAMPLE);
  // Only a clean P-high/N-low decision counts as a one; a forced timeout
  // decision has RDY low and therefore also resolves to zero.
  assign bit_val    = RDY && CMP_P && !CMP_N;
  assign k_mask     = {{(N_BITS-1){1'b0}}, 1'b1} << k;

`ifdef SAR_TIMEOUT_EN
  sar_tmo_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk    (CLK),
    .rst    (RST),
    .load   (state != ST_WAIT),
    .run    (state == ST_WAIT),
    .expire (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  // Next-state logic and decision strobe for the sample/convert sequence.
  always_comb begin
    state_next = state;
    decide     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (EN) state_next = ST_SAMPLE;
        else    state_next = ST_IDLE;
      end
      ST_SAMPLE: begin
        if (samp_done) state_next = ST_WAIT;
        else           state_next = ST_SAMPLE;
      end
      ST_WAIT: begin
        if (RDY || tmo_expire) begin
          decide     = 1'b1;
          state_next = ST_RSTC;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_RSTC: begin
        if (k == {KW{1'b0}}) state_next = ST_LATCH;
        else                 state_next = ST_WAIT;
      end
      ST_LATCH: begin
        if (EN) state_next = ST_SAMPLE;
        else    state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register, sample-window counter and bit index.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      samp_cnt <= {SW{1'b0}};
      k        <= {KW{1'b0}};
    end else begin
      state <= state_next;
      if (state == ST_SAMPLE) begin
        samp_cnt <= samp_cnt + SW'(1);
        k        <= KW'(N_BITS - 1);
      end else begin
        samp_cnt <= {SW{1'b0}};
        if ((state == ST_RSTC) && (state_next == ST_WAIT)) begin
          k <= k - KW'(1);
        end else begin
          k <= k;
        end
      end
    end
  end

  // CDAC switch and cycle-flag registers: cleared at sample entry, one bit set per decision.
  always_ff @(posedge CLK) begin
    if (RST) begin
      CF  <= {N_BITS{1'b0}};
      SWP <= {N_BITS{1'b0}};
      SWN <= {N_BITS{1'b0}};
    end else if (samp_entry) begin
      CF  <= {N_BITS{1'b0}};
      SWP <= {N_BITS{1'b0}};
      SWN <= {N_BITS{1'b0}};
    end else if (decide) begin
      CF <= CF | k_mask;
      if (bit_val) begin
        SWN <= SWN | k_mask;
        SWP <= SWP;
      end else begin
        SWN <= SWN;
        SWP <= SWP | k_mask;
      end
    end else begin
      CF  <= CF;
      SWP <= SWP;
      SWN <= SWN;
    end
  end

  // Phase outputs and result latch, loaded from the next state so they track it exactly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      CKS  <= 1'b0;
      CKSB <= 1'b1;
      CKC  <= 1'b0;
      CKO  <= 1'b0;
      DATA <= {N_BITS{1'b0}};
    end else begin
      CKS  <= (state_next == ST_SAMPLE);
      CKSB <= (state_next != ST_SAMPLE);
      CKC  <= (state_next == ST_WAIT);
      CKO  <= (state_next == ST_LATCH);
      // SWN holds the collected code: SWN[k] is set exactly when bit k is one.
      if (state_next == ST_LATCH) DATA <= SWN;
      else                        DATA <= DATA;
    end
  end

`ifdef SAR_TIMEOUT_EN
  // Sticky fault flag: timeout or ambiguous comparator output; cleared at sample entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR <= 1'b0;
    end else if (samp_entry) begin
      ERR <= 1'b0;
    end else if (decide && (!RDY || (CMP_P == CMP_N))) begin
      ERR <= 1'b1;
    end else begin
      ERR <= ERR;
    end
  end
`endif

endmodule

// File: tb/tb_sar_ctrl_nb.sv
// Self-checking bench for sar_ctrl_nb (N_BITS=9, SAMPLE_CYC=2, TIMEOUT_CYC=8).
// A comparator model answers CKC with the bits of a target code; expected
// codes and latencies come from the bit-serial timing rules:
// SAMPLE_CYC cycles of sampling plus (delay+2) cycles per bit.
module tb_sar_ctrl_nb;

  localparam int N  = 9;
  localparam int SC = 2;
  localparam int TO = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         EN = 1'b0;
  logic         RDY = 1'b0;
  logic         CMP_P = 1'b0;
  logic         CMP_N = 1'b0;
  logic         CKS, CKSB, CKC, CKO;
  logic [N-1:0] CF, SWP, SWN, DATA;
`ifdef SAR_TIMEOUT_EN
  logic         ERR;
`endif

  int checks = 0;
  int errors = 0;

  // comparator model / bookkeeping
  int           cyc = 0;
  int           abs_cyc = 0;
  int           ckc_run = 0;
  int           cur_bit = N;
  int           rdy_dly = 1;
  int           invalid_bit = -1;
  int           no_rdy_bit = -1;
  int           cko_abs = 0;
  logic [N-1:0] cmp_code = '0;
  logic [N-1:0] prev_cf, prev_swp, prev_swn;
  logic         prev_cks = 1'b0;

  always #5 CLK = ~CLK;

  sar_ctrl_nb #(.N_BITS(N), .SAMPLE_CYC(SC), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .RDY(RDY), .CMP_P(CMP_P), .CMP_N(CMP_N),
    .CKS(CKS), .CKSB(CKSB), .CKC(CKC), .CF(CF), .SWP(SWP), .SWN(SWN),
    .DATA(DATA), .CKO(CKO)
`ifdef SAR_TIMEOUT_EN
    , .ERR(ERR)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs 1ns after the edge, then let the comparator respond.
  task automatic tick();
    prev_cf  = CF;
    prev_swp = SWP;
    prev_swn = SWN;
    @(posedge CLK);
    #1;
    abs_cyc++;
    if (CKS === 1'b1 && prev_cks !== 1'b1) cyc = 0;
    else cyc++;
    prev_cks = CKS;
    if (CKS === 1'b1) cur_bit = N;
    if (CKC === 1'b1) ckc_run++;
    else ckc_run = 0;
    if (ckc_run == 1) cur_bit--;
    if (CKC === 1'b1) begin
      if (cur_bit == invalid_bit) begin
        CMP_P = 1'b1;
        CMP_N = 1'b1;
      end else if (cur_bit >= 0 && cur_bit < N) begin
        CMP_P = cmp_code[cur_bit];
        CMP_N = ~cmp_code[cur_bit];
      end
      RDY = (ckc_run > rdy_dly && cur_bit != no_rdy_bit) ? 1'b1 : 1'b0;
    end else begin
      // outside WAIT the controller must ignore all comparator activity
      RDY   = 1'($urandom_range(0, 1));
      CMP_P = 1'($urandom_range(0, 1));
      CMP_N = 1'($urandom_range(0, 1));
    end
  endtask

  // Run until CKO, then check code, latency and the pre-latch switch state.
  task automatic conv(input string tag, input logic [N-1:0] code,
                      input logic [N-1:0] exp, input int exp_lat, input int exp_gap);
    logic         ok;
    logic [N-1:0] nswp;
    int           last;
    last = cko_abs;
    cmp_code = code;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (CKO === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      chk({tag, "_cko_timeout"}, 32'(CKO), 32'd1);
    end else begin
      cko_abs = abs_cyc;
      nswp = ~prev_swp;
      chk({tag, "_data"}, 32'(DATA), 32'(exp));
      if (exp_lat >= 0) chk({tag, "_latency"}, cyc, exp_lat);
      if (exp_gap >= 0) chk({tag, "_gap"}, cko_abs - last, exp_gap);
      chk({tag, "_cf"}, 32'(prev_cf), 32'h1FF);
      chk({tag, "_swn"}, 32'(prev_swn), 32'(exp));
      chk({tag, "_nswp"}, 32'(nswp), 32'(exp));
    end
  endtask

  logic [N-1:0] b2b_codes [3];
  logic [N-1:0] r;
  logic [N-1:0] e;
  logic         cks_seen;
  int           dly;

  initial begin
    b2b_codes[0] = 9'h000;
    b2b_codes[1] = 9'h1FF;
    b2b_codes[2] = 9'h0A5;

    // reset state
    repeat (3) tick();
    chk("rst_cks", 32'(CKS), 32'd0);
    chk("rst_cksb", 32'(CKSB), 32'd1);
    chk("rst_ckc", 32'(CKC), 32'd0);
    chk("rst_cko", 32'(CKO), 32'd0);
    chk("rst_cf", 32'(CF), 32'd0);
    chk("rst_swp", 32'(SWP), 32'd0);
    chk("rst_swn", 32'(SWN), 32'd0);
    chk("rst_data", 32'(DATA), 32'd0);
`ifdef SAR_TIMEOUT_EN
    chk("rst_err", 32'(ERR), 32'd0);
`endif
    RST = 1'b0;
    repeat (2) tick();
    chk("idle_cks", 32'(CKS), 32'd0);

    // nominal conversion
    EN = 1'b1;
    conv("nominal", 9'h15A, 9'h15A, SC + 3 * N, -1);
    tick();
    chk("nominal_cko_once", 32'(CKO), 32'd0);

    // back-to-back conversions, first SAMPLE already entered above
    for (int i = 0; i < 3; i++) begin
      conv("b2b", b2b_codes[i], b2b_codes[i], SC + 3 * N, SC + 3 * N + 1);
      tick();
      chk("b2b_resample", 32'(CKS), 32'd1);
      chk("b2b_cf_clr", 32'(CF), 32'd0);
      chk("b2b_sw_clr", 32'({SWP, SWN}), 32'd0);
      chk("b2b_data_hold", 32'(DATA), 32'(b2b_codes[i]));
    end

    // EN dropped at cycle 10: conversion completes, then idle
    r = N'($urandom);
    cmp_code = r;
    while (cyc < 10) tick();
    EN = 1'b0;
    conv("endrop", r, r, SC + 3 * N, -1);
    tick();
    chk("endrop_cko_low", 32'(CKO), 32'd0);
    cks_seen = CKS;
    repeat (5) begin
      tick();
      cks_seen = cks_seen | CKS;
    end
    chk("endrop_idle_cks", 32'(cks_seen), 32'd0);

    // reset at cycle 15 of a conversion
    EN = 1'b1;
    r = N'($urandom);
    cmp_code = r;
    for (int i = 0; i < 10 && CKS !== 1'b1; i++) tick();
    chk("rstmid_started", 32'(CKS), 32'd1);
    while (cyc < 15) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rstmid_cks", 32'(CKS), 32'd0);
    chk("rstmid_cksb", 32'(CKSB), 32'd1);
    chk("rstmid_ckc", 32'(CKC), 32'd0);
    chk("rstmid_data", 32'(DATA), 32'd0);
    chk("rstmid_cf", 32'(CF), 32'd0);
    r = N'($urandom);
    conv("post_rst", r, r, SC + 3 * N, -1);

    // invalid comparator output (both high) on bit 4
    r = N'($urandom) | 9'h010;
    e = r & 9'h1EF;
    invalid_bit = 4;
    conv("invalid", r, e, SC + 3 * N, -1);
    chk("invalid_swp4", 32'(SWP[4]), 32'd1);
`ifdef SAR_TIMEOUT_EN
    chk("invalid_err", 32'(ERR), 32'd1);
`endif
    invalid_bit = -1;
    tick();
    chk("invalid_resample", 32'(CKS), 32'd1);
`ifdef SAR_TIMEOUT_EN
    chk("invalid_err_clr", 32'(ERR), 32'd0);
`endif

    // random codes and random comparator delays
    for (int i = 0; i < 4; i++) begin
      dly = $urandom_range(1, 3);
      rdy_dly = dly;
      r = N'($urandom);
      conv("random", r, r, SC + N * (dly + 2), -1);
    end
    rdy_dly = 1;

`ifdef SAR_TIMEOUT_EN
    // MSB never answered: forced to zero after TO WAIT cycles
    no_rdy_bit = N - 1;
    r = N'($urandom) | 9'h100;
    e = r & 9'h0FF;
    conv("timeout", r, e, SC + (TO + 1) + 3 * (N - 1), -1);
    chk("timeout_err", 32'(ERR), 32'd1);
    no_rdy_bit = -1;
`endif

    EN = 1'b0;
    repeat (40) tick();
    chk("final_idle_cks", 32'(CKS), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
